// File: rtl/multi_cycle_ctrl.sv
// ============================================================================
// Module   : multi_cycle_ctrl
// Purpose  : Main-control FSM for a multicycle MIPS datapath. It sequences
//            fetch, decode and execute for lw, sw, R-type, beq, addi and j.
//            It raises a one-cycle retire pulse and a sticky flag for
//            unsupported opcodes.
// Ports    : clk, rst_n      - rising-edge clock, async active-low reset
//            opcode[5:0]     - IR[31:26]
//            memReady        - memory finished the current access
//            pcWrite .. pcSrc - datapath control strobes and selects
//            instrDone       - registered pulse, instruction retired
//            illegalOp       - sticky, unsupported opcode seen
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSrc,
  output logic       instrDone,
  output logic       illegalOp
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BEQEX  = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JEX    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state;
  logic   retire;

  // The last cycle of every legal instruction; a stalled store retires only
  // once memory accepts it.
  always_comb begin
    retire = 1'b0;
    case (state)
      MEMWB, RWB, BEQEX, ADDIWB, JEX: retire = 1'b1;
      MEMWR:                          retire = memReady;
      default:                        retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      instrDone <= 1'b0;
      illegalOp <= 1'b0;
    end else begin
      instrDone <= retire;
      case (state)
        FETCH:  if (memReady) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= REXEC;
            OP_BEQ:       state <= BEQEX;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JEX;
            default: begin
              state     <= FETCH;
              illegalOp <= 1'b1;
            end
          endcase
        end
        MEMADR: state <= (opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  if (memReady) state <= MEMWB;
        MEMWB:  state <= FETCH;
        MEMWR:  if (memReady) state <= FETCH;
        REXEC:  state <= RWB;
        RWB:    state <= FETCH;
        BEQEX:  state <= FETCH;
        ADDIEX: state <= ADDIWB;
        ADDIWB: state <= FETCH;
        JEX:    state <= FETCH;
        // Unencoded values recover to FETCH.
        default: state <= FETCH;
      endcase
    end
  end

  // Moore decode of the state register. The only input-dependent terms are
  // the FETCH IR/PC load, which waits for memReady. That load is also
  // qualified by rst_n, because reset forces the state to FETCH
  // asynchronously and memReady may still be high.
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSrc       = 2'b00;
    case (state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady & rst_n;
        pcWrite = memReady & rst_n;
      end
      DECODE: aluSrcB = 2'b11;
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      MEMWR: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
      end
      REXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      RWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      BEQEX: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSrc       = 2'b01;
      end
      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      ADDIWB: regWrite = 1'b1;
      JEX: begin
        pcWrite = 1'b1;
        pcSrc   = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
// ============================================================================
// Module   : tb_multi_cycle_ctrl
// Purpose  : Scoreboard bench for multi_cycle_ctrl. Stimulus pushes the
//            expected control vector for each cycle, and a monitor pops and
//            compares it on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic       memReady = 1'b0;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSrc;
  logic       instrDone, illegalOp;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc),
    .instrDone(instrDone), .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3;
  localparam int S_MEMWB = 4, S_MEMWR = 5, S_REXEC = 6, S_RWB = 7;
  localparam int S_BEQEX = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JEX = 11;
  localparam int S_RST = 12;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic [17:0] vec;
    int          st;
    int          n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   issued = 0;
  logic exp_ill = 1'b0;

  wire [17:0] act = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                     memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
                     pcSrc, instrDone, illegalOp};

  // Per-state control table written out from the state descriptions.
  function automatic logic [17:0] expect_vec(int s, logic mr, logic done, logic ill);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = 10'b0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      S_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin iord = 1; mwr = 1; end
      S_REXEC:  begin asa = 1; aop = 2'b10; end
      S_RWB:    begin rw = 1; rdst = 1; end
      S_BEQEX:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      S_ADDIEX: begin asa = 1; asb = 2'b10; end
      S_ADDIWB: rw = 1;
      S_JEX:    begin pcw = 1; psrc = 2'b10; end
      S_RST:    begin mrd = 1; asb = 2'b01; end
      default:  ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  task automatic push(int s, logic mr, logic done);
    exp_t e;
    e.vec = expect_vec(s, mr, done, exp_ill);
    e.st  = s;
    e.n   = issued;
    issued++;
    q.push_back(e);
  endtask

  task automatic cyc(int s, logic [5:0] op, logic mr, logic done);
    @(posedge clk);
    #1;
    opcode   = op;
    memReady = mr;
    push(s, mr, done);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act !== e.vec) begin
        errors++;
        $display("FAIL step%0d state%0d: got %b want %b", e.n, e.st, act, e.vec);
      end
    end
  end

  initial begin
    // Reset value while held in reset.
    repeat (2) @(posedge clk);
    #1 push(S_RST, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // lw, memReady high throughout (5 cycles); memReady in DECODE ignored.
    cyc(S_FETCH,  LW, 1, 0);
    cyc(S_DECODE, LW, 1, 0);
    cyc(S_MEMADR, LW, 1, 0);
    cyc(S_MEMRD,  LW, 1, 0);
    cyc(S_MEMWB,  LW, 1, 0);
    // R-type (4 cycles), retire pulse from lw in its first cycle.
    cyc(S_FETCH,  RT, 1, 1);
    cyc(S_DECODE, RT, 1, 0);
    cyc(S_REXEC,  RT, 1, 0);
    cyc(S_RWB,    RT, 1, 0);
    // sw with three stall cycles in MEMWR.
    cyc(S_FETCH,  SW, 1, 1);
    cyc(S_DECODE, SW, 1, 0);
    cyc(S_MEMADR, SW, 1, 0);
    cyc(S_MEMWR,  SW, 0, 0);
    cyc(S_MEMWR,  SW, 0, 0);
    cyc(S_MEMWR,  SW, 0, 0);
    cyc(S_MEMWR,  SW, 1, 0);
    // addi with a five-cycle fetch stall.
    cyc(S_FETCH,  ADDI, 0, 1);
    cyc(S_FETCH,  ADDI, 0, 0);
    cyc(S_FETCH,  ADDI, 0, 0);
    cyc(S_FETCH,  ADDI, 0, 0);
    cyc(S_FETCH,  ADDI, 0, 0);
    cyc(S_FETCH,  ADDI, 1, 0);
    cyc(S_DECODE, ADDI, 1, 0);
    cyc(S_ADDIEX, ADDI, 1, 0);
    cyc(S_ADDIWB, ADDI, 1, 0);
    // beq (3 cycles).
    cyc(S_FETCH,  BEQ, 1, 1);
    cyc(S_DECODE, BEQ, 1, 0);
    cyc(S_BEQEX,  BEQ, 1, 0);
    // Illegal opcode: back to FETCH, sticky flag, no retire pulse.
    cyc(S_FETCH,  BAD, 1, 1);
    cyc(S_DECODE, BAD, 1, 0);
    exp_ill = 1'b1;
    cyc(S_FETCH,  JMP, 1, 0);
    cyc(S_DECODE, JMP, 1, 0);
    cyc(S_JEX,    JMP, 1, 0);
    // lw interrupted by reset in MEMRD.
    cyc(S_FETCH,  LW, 1, 1);
    cyc(S_DECODE, LW, 1, 0);
    cyc(S_MEMADR, LW, 1, 0);
    cyc(S_MEMRD,  LW, 0, 0);
    @(posedge clk);
    #1 memReady = 1'b1;
    #1 rst_n = 1'b0;
    exp_ill = 1'b0;
    push(S_RST, 1'b1, 1'b0);
    @(posedge clk);
    #1 push(S_RST, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    memReady = 1'b0;
    cyc(S_FETCH,  LW, 0, 0);
    cyc(S_FETCH,  LW, 1, 0);
    cyc(S_DECODE, LW, 1, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
